interp_phase_sched: RTL and testbench
=====================================

Name: interp_phase_sched

Overview:
- Sequencer for the transmit polyphase interpolation bank (comb branches E1..EL).
- Accepts low-rate samples from the upstream shaper over a valid/ready handshake, holds each sample on the shared branch input and pulses a common clock-enable.
- Captures all L branch outputs, then commutates them phase 0..L-1 onto one output stream with valid/ready.
- Each phase is rounded and saturated to the DAC-side width. Sits between pulse shaping and the DAC interface.

Parameters:
- L, 2, interpolation factor (number of polyphase branches), 2..8
- IN_W, 11, signed input sample width
- BR_W, 20, signed width of each branch output
- SHIFT, 8, right shift removing branch gain, 1..BR_W-2
- OUT_W, 12, signed output width, OUT_W <= BR_W-SHIFT+1

Ports:
- clk, in, 1, single clock, rising edge
- rst, in, 1, asynchronous active-high reset
- flush, in, 1, synchronous soft clear
- in_valid, in, 1, upstream sample valid
- in_ready, out, 1, sample accepted when in_valid && in_ready
- in_data, in, IN_W, signed sample
- br_in, out, IN_W, held sample driven to all branches
- br_ce, out, 1, one-cycle enable; branches advance only when high
- br_data, in, L*BR_W, branch outputs, phase p at [p*BR_W +: BR_W]; valid the cycle after br_ce
- out_valid, out, 1, output sample valid
- out_ready, in, 1, downstream ready
- out_data, out, OUT_W, rounded/saturated phase sample
- out_phase, out, max(1,clog2(L)), phase index of out_data
- busy, out, 1, high in any state other than IDLE

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous, active-high.
- Reset values: state=IDLE, in_ready=0, br_ce=0, br_in=0, out_valid=0, out_data=0, out_phase=0, busy=0, hold registers=0.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, latch in_data into br_in, go to STROBE.
  - STROBE: br_ce=1 for exactly one cycle, in_ready=0, go to CAPT.
  - CAPT: copy br_data into L hold registers, phase=0, go to EMIT.
  - EMIT: out_valid=1; out_data=sat(round(hold[phase])); out_phase=phase.
    - On out_ready with phase<L-1: phase+1.
    - On out_ready with phase==L-1: if in_valid, latch new sample, assert in_ready this cycle, go to STROBE; else go to IDLE.
- in_ready is high only in IDLE and in the final EMIT handshake cycle.
- Throughput: L+2 cycles per input when out_ready is tied high.
- Latency: in_valid accept to first out_valid is 3 cycles.
- Backpressure: with out_ready low, out_data/out_phase/out_valid hold stable; no phase skipped or repeated.
- Rounding: v = hold + 2^(SHIFT-1), then arithmetic shift right by SHIFT (round half up).
- Saturation: clamp v to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Compute in BR_W+1 bits so the rounding add cannot overflow.
- flush: in any state, next cycle is IDLE; phase=0, out_valid=0, br_ce=0. No sample is accepted in the flush cycle; in_ready=0 while flush is high. br_in and hold registers are retained.
- rst mid-operation: immediate return to reset values; the in-flight sample is discarded.
- flush takes priority over in_valid and out_ready in the same cycle.
- br_ce never asserts in two consecutive cycles. br_in changes only on an accept.

Decomposition:
- Shared package tx_interp_pkg: FSM state encoding (IDLE, STROBE, CAPT, EMIT), default L/IN_W/BR_W/SHIFT/OUT_W constants, phase-width function.
- Sub-module round_sat (parameters BR_W, SHIFT, OUT_W), purely combinational. Reused by the decimation side.

Test Plan:
1. Basic: L=2. in_data=5, br_data={p1=25600, p0=2560}, out_ready=1 → outputs 10 (phase 0), then 100 (phase 1); first out_valid 3 cycles after accept; br_ce pulses exactly once.
2. Rounding: hold=128 → 1; hold=127 → 0; hold=-128 → 0; hold=-129 → -1.
3. Saturation: hold=524287 → 2047; hold=-524288 → -2048; hold=2047*256+200 → 2047.
4. Backpressure: out_ready low for 5 cycles during phase 0 → out_data/out_phase stable, in_ready=0, no extra br_ce. After release, phases 0,1 emitted in order.
5. Back-to-back: in_valid held high, 4 samples, out_ready=1 → in_ready asserted on each final-phase handshake; 8 outputs in order; L+2=4 cycles per sample.
6. flush in EMIT phase 1 and rst asserted during STROBE → next cycle IDLE, out_valid=0, br_ce=0; next accepted sample restarts at phase 0.

Source files
------------

// File: rtl/tx_interp_pkg.sv
// Shared definitions for the transmit polyphase interpolation path.
//
// Contents:
//   - state_t       : sequencer states (IDLE, STROBE, CAPT, EMIT)
//   - DEF_*         : default interpolation factor and datapath widths
//   - phase_w()     : width of a phase index for a given number of branches
package tx_interp_pkg;

    localparam int DEF_L     = 2;
    localparam int DEF_IN_W  = 11;
    localparam int DEF_BR_W  = 20;
    localparam int DEF_SHIFT = 8;
    localparam int DEF_OUT_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_CAPT   = 2'd2,
        ST_EMIT   = 2'd3
    } state_t;

    // A phase index needs at least one bit, even for a single pair of branches.
    function automatic int phase_w(input int l);
        return (l <= 2) ? 1 : $clog2(l);
    endfunction

endpackage

// File: rtl/round_sat.sv
// Round-half-up and saturate a signed branch value down to the DAC-side width.
//
// Ports:
//   din  : signed BR_W-bit branch value
//   dout : signed OUT_W-bit result, round(din / 2^SHIFT) clamped to the
//          OUT_W two's complement range
//
// Purely combinational; shared with the decimation side.
module round_sat #(
    parameter int BR_W  = 20,
    parameter int SHIFT = 8,
    parameter int OUT_W = 12
) (
    input  logic [BR_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);

    localparam logic signed [BR_W:0] HALF  = (BR_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [BR_W:0] MAX_V = (BR_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    // In two's complement the most negative code is the bitwise inverse of the most positive.
    localparam logic signed [BR_W:0] MIN_V = ~MAX_V;

    logic signed [BR_W:0] ext;
    logic signed [BR_W:0] rnd;
    logic signed [BR_W:0] shr;

    // One guard bit keeps the rounding add from wrapping at the top of the range.
    always_comb begin
        ext = $signed({din[BR_W-1], din});
        rnd = ext + HALF;
        shr = rnd >>> SHIFT;
        if (shr > MAX_V) begin
            dout = MAX_V[OUT_W-1:0];
        end else if (shr < MIN_V) begin
            dout = MIN_V[OUT_W-1:0];
        end else begin
            dout = shr[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/interp_phase_sched.sv
// Sequencer for the transmit polyphase interpolation bank.
//
// Takes one low-rate sample at a time from the pulse shaper, holds it on the
// shared branch input, strobes the branches once, captures all L branch
// outputs and then commutates them phase 0..L-1 onto the output stream, each
// rounded and saturated to the DAC-side width.
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   flush                 : synchronous soft clear back to IDLE
//   in_valid/in_ready     : upstream sample handshake, in_data the sample
//   br_in                 : sample held for all branches
//   br_ce                 : single-cycle branch advance strobe
//   br_data               : all branch outputs, phase p at [p*BR_W +: BR_W]
//   out_valid/out_ready   : downstream handshake
//   out_data, out_phase   : rounded/saturated sample and its phase index
//   busy                  : sequencer is not idle
module interp_phase_sched
    import tx_interp_pkg::*;
#(
    parameter int  L     = DEF_L,
    parameter int  IN_W  = DEF_IN_W,
    parameter int  BR_W  = DEF_BR_W,
    parameter int  SHIFT = DEF_SHIFT,
    parameter int  OUT_W = DEF_OUT_W,
    localparam int PW    = phase_w(L)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic [IN_W-1:0]   br_in,
    output logic              br_ce,
    input  logic [L*BR_W-1:0] br_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [PW-1:0]     out_phase,
    output logic              busy
);

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [IN_W-1:0] br_in_q, br_in_d;
    logic [BR_W-1:0] hold_q [L];
    logic [BR_W-1:0] hold_d [L];
    logic            last_phase;

    assign last_phase = (phase_q == PW'(L - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            br_in_q <= '0;
            for (int p = 0; p < L; p++) begin
                hold_q[p] <= '0;
            end
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            br_in_q <= br_in_d;
            for (int p = 0; p < L; p++) begin
                hold_q[p] <= hold_d[p];
            end
        end
    end

    // Next state. flush overrides everything but leaves the held sample and
    // captured branch values alone. The final EMIT handshake can chain
    // straight into the next STROBE so back-to-back samples cost L+2 cycles.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        br_in_d = br_in_q;
        for (int p = 0; p < L; p++) begin
            hold_d[p] = hold_q[p];
        end
        if (flush) begin
            state_d = ST_IDLE;
            phase_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        br_in_d = in_data;
                        state_d = ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    state_d = ST_CAPT;
                end
                ST_CAPT: begin
                    for (int p = 0; p < L; p++) begin
                        hold_d[p] = br_data[p*BR_W +: BR_W];
                    end
                    phase_d = '0;
                    state_d = ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (last_phase) begin
                            phase_d = '0;
                            if (in_valid) begin
                                br_in_d = in_data;
                                state_d = ST_STROBE;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            phase_d = phase_q + PW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Handshake and strobe outputs. in_ready is also held low while reset is
    // asserted so nothing looks acceptable before the sequencer is running.
    always_comb begin
        in_ready  = 1'b0;
        br_ce     = 1'b0;
        out_valid = 1'b0;
        if (!rst && !flush) begin
            case (state_q)
                ST_IDLE:   in_ready = 1'b1;
                ST_STROBE: br_ce = 1'b1;
                ST_EMIT: begin
                    out_valid = 1'b1;
                    in_ready  = out_ready && last_phase;
                end
                default: ;
            endcase
        end
    end

    round_sat #(
        .BR_W  (BR_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .din  (hold_q[phase_q]),
        .dout (out_data)
    );

    assign br_in     = br_in_q;
    assign out_phase = phase_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_interp_phase_sched.sv
// Self-checking bench for interp_phase_sched with L=2.
//
// A simple branch-bank stand-in presents per-sample branch values on br_data
// after each br_ce. Expected outputs come from an arithmetic round/saturate
// model (floor division of value + half-LSB, then clamp).
module tb_interp_phase_sched;

    localparam int L     = 2;
    localparam int IN_W  = 11;
    localparam int BR_W  = 20;
    localparam int SHIFT = 8;
    localparam int OUT_W = 12;
    localparam int PW    = 1;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic [IN_W-1:0]   br_in;
    logic              br_ce;
    logic [L*BR_W-1:0] br_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [PW-1:0]     out_phase;
    logic              busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int din;
        int b0;
        int b1;
    } samp_t;

    samp_t stim_q[$];
    samp_t pend_q[$];
    int    got_d[$];
    int    got_p[$];
    int    acc_cyc[$];
    int    ce_cyc[$];
    int    ce_brin[$];
    int    exp_d[$];
    int    exp_p[$];
    int    first_valid;

    interp_phase_sched #(
        .L     (L),
        .IN_W  (IN_W),
        .BR_W  (BR_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .br_in     (br_in),
        .br_ce     (br_ce),
        .br_data   (br_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_phase (out_phase),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: round half up as floor((h + 2^(SHIFT-1)) / 2^SHIFT), then clamp.
    function automatic int ref_rs(input int h);
        longint v, q, hi, lo, div;
        div = longint'(1) << SHIFT;
        v   = longint'(h) + (longint'(1) << (SHIFT - 1));
        if (v >= 0) q = v / div;
        else        q = -((-v + div - 1) / div);
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return int'(q);
    endfunction

    function automatic int rand_br();
        return int'($urandom_range(0, (1 << BR_W) - 1)) - (1 << (BR_W - 1));
    endfunction

    function automatic int rand_din();
        return int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
    endfunction

    // Expected stream for everything in stim_q: every sample yields phases 0..L-1.
    function automatic void build_model();
        exp_d.delete();
        exp_p.delete();
        foreach (stim_q[i]) begin
            for (int p = 0; p < L; p++) begin
                exp_d.push_back(ref_rs(p == 0 ? stim_q[i].b0 : stim_q[i].b1));
                exp_p.push_back(p);
            end
        end
    endfunction

    task automatic set_br(input samp_t s);
        br_data = {BR_W'(s.b1), BR_W'(s.b0)};
    endtask

    // Drives stim_q into the DUT with random valid/ready density and records
    // what comes out. Inputs change at the falling edge; outputs are read 1ns later.
    task automatic run_stream(input int valid_pct, input int ready_pct, input int max_cycles);
        int cyc;
        int sent;
        int n;
        n = stim_q.size();
        got_d.delete(); got_p.delete(); acc_cyc.delete();
        ce_cyc.delete(); ce_brin.delete(); pend_q.delete();
        first_valid = -1;
        cyc  = 0;
        sent = 0;
        while ((sent < n || got_d.size() < n * L) && cyc < max_cycles) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (sent < n) begin
                in_valid = (int'($urandom_range(0, 99)) < valid_pct);
                in_data  = IN_W'(stim_q[sent].din);
            end
            out_ready = (int'($urandom_range(0, 99)) < ready_pct);
            #1;
            if (br_ce) begin
                ce_cyc.push_back(cyc);
                ce_brin.push_back(int'($signed(br_in)));
                if (pend_q.size() > 0) set_br(pend_q.pop_front());
            end
            if (in_valid && in_ready) begin
                pend_q.push_back(stim_q[sent]);
                acc_cyc.push_back(cyc);
                sent++;
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready) begin
                got_d.push_back(int'($signed(out_data)));
                got_p.push_back(int'(out_phase));
            end
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; br_data = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({in_ready, br_ce, out_valid, busy} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: {in_ready,br_ce,out_valid,busy} got %b expected 0000",
                     {in_ready, br_ce, out_valid, busy});
        end
        checks++;
        if (br_in !== '0 || out_data !== '0 || out_phase !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: br_in=%0d out_data=%0d out_phase=%0d expected all 0",
                     br_in, out_data, out_phase);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: in_ready=%b busy=%b expected 1/0", in_ready, busy);
        end
    endtask

    task automatic test_basic();
        int ed[$];
        stim_q.delete();
        stim_q.push_back('{5, 2560, 25600});
        run_stream(100, 100, 30);
        ed = '{10, 100};
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_d.size() <= i || got_d[i] !== ed[i] || got_p[i] !== i) begin
                errors++;
                $display("[TB] FAIL basic_out[%0d]: got %0d ph %0d expected %0d ph %0d",
                         i, (got_d.size() > i) ? got_d[i] : -99999, (got_p.size() > i) ? got_p[i] : -1, ed[i], i);
            end
        end
        checks++;
        if (acc_cyc.size() != 1 || first_valid - acc_cyc[0] != 3) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d cycles expected 3", first_valid - ((acc_cyc.size() > 0) ? acc_cyc[0] : 0));
        end
        checks++;
        if (ce_cyc.size() != 1) begin
            errors++;
            $display("[TB] FAIL basic_br_ce_count: got %0d expected 1", ce_cyc.size());
        end
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_rounding();
        int ed[$];
        stim_q.delete();
        stim_q.push_back('{1, 128, 127});
        stim_q.push_back('{2, -128, -129});
        run_stream(100, 100, 40);
        ed = '{1, 0, 0, -1};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_d.size() <= i || got_d[i] !== ed[i] || got_p[i] !== i % L) begin
                errors++;
                $display("[TB] FAIL round_out[%0d]: got %0d expected %0d ph %0d",
                         i, (got_d.size() > i) ? got_d[i] : -99999, ed[i], i % L);
            end
        end
    endtask

    task automatic test_saturation();
        int ed[$];
        stim_q.delete();
        stim_q.push_back('{3, 524287, -524288});
        stim_q.push_back('{4, 2047 * 256 + 200, 0});
        run_stream(100, 100, 40);
        ed = '{2047, -2048, 2047, 0};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_d.size() <= i || got_d[i] !== ed[i] || got_p[i] !== i % L) begin
                errors++;
                $display("[TB] FAIL sat_out[%0d]: got %0d expected %0d ph %0d",
                         i, (got_d.size() > i) ? got_d[i] : -99999, ed[i], i % L);
            end
        end
    endtask

    task automatic test_backpressure();
        samp_t s;
        int k;
        int d0;
        int n_ce;
        int od[$];
        int op[$];
        s = '{3, 1000, -5000};
        set_br(s);
        @(negedge clk);
        in_valid = 1'b1; in_data = IN_W'(s.din); out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_accept: in_ready=%b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        k = 0;
        while (!out_valid && k < 10) begin
            @(negedge clk); #1; k++;
        end
        d0 = int'($signed(out_data));
        checks++;
        if (out_valid !== 1'b1 || d0 !== ref_rs(s.b0) || out_phase !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_first: valid=%b data=%0d ph=%0d expected 1/%0d/0",
                     out_valid, d0, out_phase, ref_rs(s.b0));
        end
        n_ce = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (br_ce) n_ce++;
            checks++;
            if (out_valid !== 1'b1 || int'($signed(out_data)) !== d0 || out_phase !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_stall[%0d]: valid=%b data=%0d ph=%0d in_ready=%b expected 1/%0d/0/0",
                         c, out_valid, $signed(out_data), out_phase, in_ready, d0);
            end
        end
        checks++;
        if (n_ce != 0) begin
            errors++;
            $display("[TB] FAIL bp_br_ce: got %0d pulses during stall expected 0", n_ce);
        end
        k = 0;
        while (od.size() < L && k < 10) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                od.push_back(int'($signed(out_data)));
                op.push_back(int'(out_phase));
            end
            k++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < L; i++) begin
            checks++;
            if (od.size() <= i || od[i] !== ref_rs(i == 0 ? s.b0 : s.b1) || op[i] !== i) begin
                errors++;
                $display("[TB] FAIL bp_release[%0d]: got %0d ph %0d expected %0d ph %0d",
                         i, (od.size() > i) ? od[i] : -99999, (op.size() > i) ? op[i] : -1,
                         ref_rs(i == 0 ? s.b0 : s.b1), i);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_q.delete();
        for (int i = 0; i < 4; i++) stim_q.push_back('{rand_din(), rand_br(), rand_br()});
        build_model();
        run_stream(100, 100, 60);
        for (int i = 0; i < exp_d.size(); i++) begin
            checks++;
            if (got_d.size() <= i || got_d[i] !== exp_d[i] || got_p[i] !== exp_p[i]) begin
                errors++;
                $display("[TB] FAIL b2b_out[%0d]: got %0d expected %0d ph %0d",
                         i, (got_d.size() > i) ? got_d[i] : -99999, exp_d[i], exp_p[i]);
            end
        end
        checks++;
        if (acc_cyc.size() != 4) begin
            errors++;
            $display("[TB] FAIL b2b_accepts: got %0d expected 4", acc_cyc.size());
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != L + 2) begin
                errors++;
                $display("[TB] FAIL b2b_spacing[%0d]: got %0d cycles expected %0d",
                         i, acc_cyc[i] - acc_cyc[i-1], L + 2);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ce_brin.size() <= i || ce_brin[i] !== stim_q[i].din) begin
                errors++;
                $display("[TB] FAIL b2b_br_in[%0d]: got %0d expected %0d",
                         i, (ce_brin.size() > i) ? ce_brin[i] : -99999, stim_q[i].din);
            end
        end
    endtask

    task automatic test_random();
        stim_q.delete();
        for (int i = 0; i < 16; i++) stim_q.push_back('{rand_din(), rand_br(), rand_br()});
        build_model();
        run_stream(60, 60, 1500);
        for (int i = 0; i < exp_d.size(); i++) begin
            checks++;
            if (got_d.size() <= i || got_d[i] !== exp_d[i] || got_p[i] !== exp_p[i]) begin
                errors++;
                $display("[TB] FAIL rand_out[%0d]: got %0d ph %0d expected %0d ph %0d",
                         i, (got_d.size() > i) ? got_d[i] : -99999, (got_p.size() > i) ? got_p[i] : -1,
                         exp_d[i], exp_p[i]);
            end
        end
        checks++;
        if (ce_cyc.size() != 16) begin
            errors++;
            $display("[TB] FAIL rand_br_ce_count: got %0d expected 16", ce_cyc.size());
        end
        for (int i = 1; i < ce_cyc.size(); i++) begin
            checks++;
            if (ce_cyc[i] - ce_cyc[i-1] < 2) begin
                errors++;
                $display("[TB] FAIL rand_br_ce_gap[%0d]: got %0d expected >= 2", i, ce_cyc[i] - ce_cyc[i-1]);
            end
        end
        for (int i = 0; i < ce_brin.size() && i < 16; i++) begin
            checks++;
            if (ce_brin[i] !== stim_q[i].din) begin
                errors++;
                $display("[TB] FAIL rand_br_in[%0d]: got %0d expected %0d", i, ce_brin[i], stim_q[i].din);
            end
        end
    endtask

    task automatic test_flush();
        samp_t s;
        int k;
        s = '{7, 3000, -3000};
        set_br(s);
        @(negedge clk);
        in_valid = 1'b1; in_data = IN_W'(s.din); out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        k = 0;
        while (!out_valid && k < 10) begin
            @(negedge clk); #1; k++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_phase !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_setup: valid=%b ph=%0d expected 1/1", out_valid, out_phase);
        end
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_data = IN_W'(-100); out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_in_ready: got %b expected 0", in_ready);
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++;
        if ({busy, out_valid, br_ce} !== 3'b000 || out_phase !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_idle: {busy,out_valid,br_ce}=%b ph=%0d expected 000/0",
                     {busy, out_valid, br_ce}, out_phase);
        end
        checks++;
        if (int'($signed(br_in)) !== s.din) begin
            errors++;
            $display("[TB] FAIL flush_br_in: got %0d expected %0d", $signed(br_in), s.din);
        end
        @(negedge clk);
        #1;
        checks++;
        if (br_ce !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_no_accept: br_ce=%b busy=%b expected 0/0", br_ce, busy);
        end
        stim_q.delete();
        stim_q.push_back('{12, 700, -700});
        build_model();
        run_stream(100, 100, 30);
        for (int i = 0; i < L; i++) begin
            checks++;
            if (got_d.size() <= i || got_d[i] !== exp_d[i] || got_p[i] !== exp_p[i]) begin
                errors++;
                $display("[TB] FAIL flush_restart[%0d]: got %0d expected %0d ph %0d",
                         i, (got_d.size() > i) ? got_d[i] : -99999, exp_d[i], exp_p[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        samp_t s;
        int k;
        s = '{9, 5000, 6000};
        set_br(s);
        @(negedge clk);
        in_valid = 1'b1; in_data = IN_W'(s.din); out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        k = 0;
        while (!br_ce && k < 5) begin
            @(negedge clk); #1; k++;
        end
        checks++;
        if (br_ce !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_strobe: br_ce=%b expected 1", br_ce);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, br_ce, out_valid, busy} !== 4'b0000 || br_in !== '0 || out_data !== '0 || out_phase !== '0) begin
            errors++;
            $display("[TB] FAIL rstmid_values: ctrl=%b br_in=%0d out_data=%0d ph=%0d expected all 0",
                     {in_ready, br_ce, out_valid, busy}, br_in, out_data, out_phase);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_release: in_ready=%b expected 1", in_ready);
        end
        stim_q.delete();
        stim_q.push_back('{-20, -40000, 90000});
        build_model();
        run_stream(100, 100, 30);
        for (int i = 0; i < L; i++) begin
            checks++;
            if (got_d.size() <= i || got_d[i] !== exp_d[i] || got_p[i] !== exp_p[i]) begin
                errors++;
                $display("[TB] FAIL rstmid_restart[%0d]: got %0d expected %0d ph %0d",
                         i, (got_d.size() > i) ? got_d[i] : -99999, exp_d[i], exp_p[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
